// File: rtl/toy_wb_arbiter_pkg.sv
// Shared writeback types and defaults for the toy core.
// Holds the buffered result entry layout and the arbiter defaults.
package toy_pack;

  localparam int REG_WIDTH      = 32;
  localparam int INST_IDX_WIDTH = 6;
  localparam int WB_NUM_SRC     = 3;
  localparam int WB_FIFO_DEPTH  = 4;

  typedef struct packed {
    logic                      wr_en;
    logic [4:0]                reg_index;
    logic [REG_WIDTH-1:0]      reg_val;
    logic [INST_IDX_WIDTH-1:0] inst_idx;
  } wb_entry_t;

endpackage

// File: rtl/toy_wb_arbiter_if.sv
// Execute-unit result bus: per-source fire-and-forget results plus
// src_rdy back-pressure. master = execute side, slave = arbiter.
interface toy_wb_arbiter_if #(
  parameter int NUM_SRC = toy_pack::WB_NUM_SRC
);
  import toy_pack::*;

  logic [NUM_SRC-1:0]                src_commit_en;
  logic [NUM_SRC-1:0]                src_wr_en;
  logic [NUM_SRC*5-1:0]              src_reg_index;
  logic [NUM_SRC*REG_WIDTH-1:0]      src_reg_val;
  logic [NUM_SRC*INST_IDX_WIDTH-1:0] src_inst_idx;
  logic [NUM_SRC-1:0]                src_rdy;

  modport master (
    output src_commit_en,
    output src_wr_en,
    output src_reg_index,
    output src_reg_val,
    output src_inst_idx,
    input  src_rdy
  );

  modport slave (
    input  src_commit_en,
    input  src_wr_en,
    input  src_reg_index,
    input  src_reg_val,
    input  src_inst_idx,
    output src_rdy
  );

endinterface

// File: rtl/toy_wb_arbiter_fifo.sv
// Per-source result FIFO of wb_entry_t.
// Ports: push/pop, din/dout (head), empty, full, count.
module toy_wb_fifo
  import toy_pack::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  wb_entry_t   din,
  output wb_entry_t   dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // a full FIFO still accepts when its head leaves this cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/toy_wb_arbiter.sv
// Buffers execute-unit results per source and drains them round-robin
// into the single RF write port and commit port, one per cycle.
module toy_wb_arbiter
  import toy_pack::*;
#(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  toy_wb_arbiter_if.slave           bus,
  output logic                      rf_wr_en,
  output logic [4:0]                rf_wr_index,
  output logic [REG_WIDTH-1:0]      rf_wr_val,
  output logic                      commit_en,
  output logic [INST_IDX_WIDTH-1:0] commit_inst_idx,
  output logic                      overflow_err
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  wb_entry_t din  [NUM_SRC];
  wb_entry_t dout [NUM_SRC];
  logic [AW:0] count [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pop;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign din[gi] = '{
      wr_en:     bus.src_wr_en[gi],
      reg_index: bus.src_reg_index[gi*5 +: 5],
      reg_val:   bus.src_reg_val[gi*REG_WIDTH +: REG_WIDTH],
      inst_idx:  bus.src_inst_idx[gi*INST_IDX_WIDTH +: INST_IDX_WIDTH]
    };

    assign bus.src_rdy[gi] = (count[gi] < (AW+1)'(FIFO_DEPTH));

    toy_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.src_commit_en[gi]),
      .pop   (pop[gi]),
      .din   (din[gi]),
      .dout  (dout[gi]),
      .empty (empty[gi]),
      .full  (full[gi]),
      .count (count[gi])
    );
  end

  logic [SW-1:0] last_grant;
  logic [SW-1:0] grant;
  logic [SW-1:0] cand;
  logic          grant_valid;
  logic          ovf_now;
  wb_entry_t     head;

  // first non-empty source after the previous winner
  always_comb begin
    grant       = last_grant;
    cand        = last_grant;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SW'((int'(last_grant) + k) % NUM_SRC);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    pop        = '0;
    pop[grant] = grant_valid;
  end

  assign head    = dout[grant];
  assign ovf_now = |(bus.src_commit_en & full & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= SW'(NUM_SRC - 1);
      rf_wr_en        <= 1'b0;
      rf_wr_index     <= '0;
      rf_wr_val       <= '0;
      commit_en       <= 1'b0;
      commit_inst_idx <= '0;
      overflow_err    <= 1'b0;
    end else begin
      commit_en <= grant_valid;
      // x0 commits but never writes
      rf_wr_en  <= grant_valid & head.wr_en & (head.reg_index != 5'd0);
      if (grant_valid) begin
        last_grant      <= grant;
        commit_inst_idx <= head.inst_idx;
        rf_wr_index     <= head.reg_index;
        rf_wr_val       <= head.reg_val;
      end
      if (ovf_now) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_wb_arbiter.sv
// Self-checking bench for toy_wb_arbiter: directed scenarios plus a
// random phase, all scored against a queue-based reference model.
module tb_toy_wb_arbiter;

  localparam int NS  = 3;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_wr_en;
  logic [4:0] rf_wr_index;
  logic [31:0] rf_wr_val;
  logic commit_en;
  logic [5:0] commit_inst_idx;
  logic overflow_err;

  int total = 0;
  int bad = 0;

  toy_wb_arbiter_if #(.NUM_SRC(NS)) bus ();

  toy_wb_arbiter #(
    .NUM_SRC    (NS),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_index     (rf_wr_index),
    .rf_wr_val       (rf_wr_val),
    .commit_en       (commit_en),
    .commit_inst_idx (commit_inst_idx),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  // reference model: one queue per source, entry = {wr, rd, val, idx}
  bit [43:0] mq [NS][$];
  int rr;
  bit m_commit, m_wr, m_ovf;
  bit [4:0] m_index;
  bit [31:0] m_val;
  bit [5:0] m_idx;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int next_grant();
    for (int k = 1; k <= NS; k++)
      if (mq[(rr + k) % NS].size() > 0) return (rr + k) % NS;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    rr = NS - 1;
    m_commit = 0; m_wr = 0; m_ovf = 0;
    m_index = 0; m_val = 0; m_idx = 0;
  endtask

  task automatic model_edge();
    int g;
    bit [43:0] e;
    g = next_grant();
    m_commit = (g >= 0);
    m_wr = 0;
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_idx = e[5:0];
      m_val = e[37:6];
      m_index = e[42:38];
      m_wr = e[43] && (e[42:38] != 5'd0);
      rr = g;
    end
    for (int i = 0; i < NS; i++) begin
      if (bus.src_commit_en[i]) begin
        if (mq[i].size() < DEP)
          mq[i].push_back({bus.src_wr_en[i], bus.src_reg_index[i*5 +: 5],
                           bus.src_reg_val[i*32 +: 32],
                           bus.src_inst_idx[i*6 +: 6]});
        else
          m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("commit_en", commit_en, m_commit);
    chk("commit_idx", commit_inst_idx, m_idx);
    chk("rf_wr_en", rf_wr_en, m_wr);
    chk("rf_wr_index", rf_wr_index, m_index);
    chk("rf_wr_val", rf_wr_val, m_val);
    chk("overflow_err", overflow_err, m_ovf);
    for (int i = 0; i < NS; i++)
      chk($sformatf("src_rdy%0d", i), bus.src_rdy[i], mq[i].size() < DEP);
  endtask

  task automatic clr();
    bus.src_commit_en = '0;
    bus.src_wr_en = '0;
    bus.src_reg_index = '0;
    bus.src_reg_val = '0;
    bus.src_inst_idx = '0;
  endtask

  task automatic set_src(int s, bit we, bit [4:0] rd, bit [31:0] val,
                         bit [5:0] idx);
    bus.src_commit_en[s] = 1'b1;
    bus.src_wr_en[s] = we;
    bus.src_reg_index[s*5 +: 5] = rd;
    bus.src_reg_val[s*32 +: 32] = val;
    bus.src_inst_idx[s*6 +: 6] = idx;
  endtask

  task automatic rnd_src(int s);
    set_src(s, 1'($urandom), 5'($urandom), $urandom, 6'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    clr();
  endtask

  // async pulse between edges; caller is just after a posedge
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_commit_en", commit_en, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_rf_wr_index", rf_wr_index, 0);
    chk("rst_rf_wr_val", rf_wr_val, 0);
    chk("rst_commit_idx", commit_inst_idx, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_rdy", bus.src_rdy, 3'b111);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit fp_done;
    clr();
    model_reset();
    #2;
    chk("por_commit_en", commit_en, 0);
    chk("por_rf_wr_en", rf_wr_en, 0);
    chk("por_overflow", overflow_err, 0);
    chk("por_rdy", bus.src_rdy, 3'b111);
    #10 rst_n = 1'b1;

    // single write: visible two edges after the push
    set_src(0, 1, 5'd5, 32'h1234_5678, 6'd3);
    step();
    chk("single_early", commit_en, 0);
    step();
    chk("single_wr_en", rf_wr_en, 1);
    chk("single_index", rf_wr_index, 5);
    chk("single_val", rf_wr_val, 32'h1234_5678);
    chk("single_idx", commit_inst_idx, 3);
    step();
    chk("single_after", {commit_en, rf_wr_en}, 2'b00);

    // x0 write and no-write both commit without writing
    set_src(1, 1, 5'd0, 32'hFFFF_FFFF, 6'd7);
    step();
    set_src(1, 0, 5'd9, 32'h0000_00AA, 6'd8);
    step();
    chk("x0_commit", {commit_en, rf_wr_en, commit_inst_idx}, {2'b10, 6'd7});
    step();
    chk("nowr_commit", {commit_en, rf_wr_en, commit_inst_idx}, {2'b10, 6'd8});
    step();

    // round-robin from source 0 after reset
    pulse_reset();
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < NS; s++)
        set_src(s, 1, 5'(s + 1), 32'(s), 6'(10 + 3*b + s));
      step();
      for (int s = 0; s < NS; s++) begin
        step();
        chk("rr_order", commit_inst_idx, 10 + 3*b + s);
      end
    end
    step();

    // random traffic honouring src_rdy
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < NS; s++)
        if (mq[s].size() < DEP && $urandom_range(1, 0) == 1) rnd_src(s);
      step();
    end
    for (int c = 0; c < 15; c++) step();

    // flood all sources: buffers fill and overflow latches
    for (int c = 0; c < 10; c++) begin
      for (int s = 0; s < NS; s++) rnd_src(s);
      step();
    end
    chk("flood_ovf", overflow_err, 1);
    step();
    chk("flood_ovf_sticky", overflow_err, 1);
    pulse_reset();

    // src0 alone: drained every cycle, never fills
    for (int c = 0; c < 8; c++) begin
      rnd_src(0);
      step();
      chk("solo_rdy", bus.src_rdy[0], 1);
    end
    step();
    chk("solo_ovf", overflow_err, 0);

    // full FIFO0 pushed in the cycle it is granted
    pulse_reset();
    fp_done = 0;
    for (int c = 0; c < 60 && !fp_done; c++) begin
      for (int s = 1; s < NS; s++)
        if (mq[s].size() < DEP) rnd_src(s);
      if (mq[0].size() < DEP) begin
        set_src(0, 1, 5'd3, $urandom, 6'(c));
      end else if (next_grant() == 0) begin
        set_src(0, 1, 5'd3, $urandom, 6'(c));
        fp_done = 1;
      end
      step();
    end
    chk("fullpop_rdy", bus.src_rdy[0], 0);
    for (int c = 0; c < 16; c++) step();
    chk("fullpop_ovf", overflow_err, 0);

    // reset with work queued, then src0 wins first
    for (int s = 0; s < NS; s++) rnd_src(s);
    step();
    step();
    chk("pre_rst_commit", commit_en, 1);
    pulse_reset();
    step();
    chk("post_rst_idle", commit_en, 0);
    set_src(1, 1, 5'd4, 32'hBEEF, 6'd21);
    set_src(0, 1, 5'd2, 32'hCAFE, 6'd20);
    step();
    step();
    chk("post_rst_first", commit_inst_idx, 20);
    step();
    chk("post_rst_second", commit_inst_idx, 21);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
